debug_trace_serializer: RTL and testbench

DEBUG_TRACE_SERIALIZER -- requirements
Module: debug_trace_serializer

---
 rtl/debug_trace_serializer.sv | 138 +++++++++++++
 tb/tb_debug_trace_serializer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_trace_serializer.sv
// Debug trace serializer: snapshots CPU architectural state on a committed
// machine cycle and streams it as a byte frame over a valid/ready link.
module debug_trace_serializer #(
  parameter int REG_DUMP = 1
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              enable,
  input  logic              machineCycleDone,
  input  logic [31:0][31:0] regfileState,
  input  logic [31:0]       nextPCState,
  input  logic [3:0]        flagsState,
  input  logic [7:0]        systemCallState,
  input  logic [31:0]       isrBaseAddressState,
  input  logic              interruptEnableState,
  input  logic [15:0]       exceptionMaskState,
  input  logic [4:0]        causeState,
  output logic [7:0]        txData,
  output logic              txValid,
  input  logic              txReady,
  output logic              busy,
  output logic [7:0]        dropCount
);

  localparam logic [7:0] LAST_IDX = (REG_DUMP != 0) ? 8'd143 : 8'd15;

  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_next;

  logic [7:0]        idx;
  logic [7:0]        seq_cnt;
  logic [7:0]        csum;
  logic [7:0]        frame_byte;
  logic [6:0]        reg_off;

  logic [7:0]        snap_seq;
  logic [31:0][31:0] snap_regs;
  logic [31:0]       snap_pc;
  logic [3:0]        snap_flags;
  logic [7:0]        snap_syscall;
  logic [31:0]       snap_isr;
  logic              snap_ie;
  logic [15:0]       snap_mask;
  logic [4:0]        snap_cause;

  logic handshake, final_hs, capture, drop;

  assign handshake = (state == SEND) && txReady;
  assign final_hs  = handshake && (idx == LAST_IDX);
  assign capture   = enable && machineCycleDone && ((state == IDLE) || final_hs);
  assign drop      = enable && machineCycleDone && (state == SEND) && !final_hs;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (capture) state_next = SEND;
      SEND:    if (final_hs && !capture) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    txValid = (state == SEND);
    busy    = (state == SEND);
    txData  = (state == SEND) ? frame_byte : '0;
  end

  // Frame byte selection; the checksum slot wins over the register-dump default.
  always_comb begin
    reg_off    = idx[6:0] - 7'd15;
    frame_byte = '0;
    if (idx == LAST_IDX) begin
      frame_byte = csum;
    end else begin
      case (idx)
        8'd0:    frame_byte = 8'hA5;
        8'd1:    frame_byte = snap_seq;
        8'd2:    frame_byte = snap_pc[7:0];
        8'd3:    frame_byte = snap_pc[15:8];
        8'd4:    frame_byte = snap_pc[23:16];
        8'd5:    frame_byte = snap_pc[31:24];
        8'd6:    frame_byte = {3'b000, snap_ie, snap_flags};
        8'd7:    frame_byte = snap_syscall;
        8'd8:    frame_byte = {3'b000, snap_cause};
        8'd9:    frame_byte = snap_mask[7:0];
        8'd10:   frame_byte = snap_mask[15:8];
        8'd11:   frame_byte = snap_isr[7:0];
        8'd12:   frame_byte = snap_isr[15:8];
        8'd13:   frame_byte = snap_isr[23:16];
        8'd14:   frame_byte = snap_isr[31:24];
        default: frame_byte = snap_regs[reg_off[6:2]][{reg_off[1:0], 3'b000} +: 8];
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      idx          <= '0;
      seq_cnt      <= '0;
      csum         <= '0;
      dropCount    <= '0;
      snap_seq     <= '0;
      snap_regs    <= '0;
      snap_pc      <= '0;
      snap_flags   <= '0;
      snap_syscall <= '0;
      snap_isr     <= '0;
      snap_ie      <= 1'b0;
      snap_mask    <= '0;
      snap_cause   <= '0;
    end else begin
      if (capture) begin
        idx          <= '0;
        csum         <= '0;
        seq_cnt      <= seq_cnt + 8'd1;
        snap_seq     <= seq_cnt;
        snap_regs    <= regfileState;
        snap_pc      <= nextPCState;
        snap_flags   <= flagsState;
        snap_syscall <= systemCallState;
        snap_isr     <= isrBaseAddressState;
        snap_ie      <= interruptEnableState;
        snap_mask    <= exceptionMaskState;
        snap_cause   <= causeState;
      end else if (handshake) begin
        idx  <= idx + 8'd1;
        csum <= csum ^ frame_byte;
      end
      if (drop && (dropCount != 8'hFF)) dropCount <= dropCount + 8'd1;
    end
  end

endmodule

// File: tb/tb_debug_trace_serializer.sv
// Directed bench for debug_trace_serializer: one short-frame and one
// register-dump instance share the CPU state inputs.
module tb_debug_trace_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              resetN, en0, en1, mcd, rdy0, rdy1, ie;
  logic [31:0][31:0] regs;
  logic [31:0]       pc, isr;
  logic [3:0]        flags;
  logic [7:0]        sc;
  logic [15:0]       mask;
  logic [4:0]        cause;

  logic [7:0] d0, d1, dc0, dc1;
  logic       v0, v1, b0, b1;

  int pass_cnt = 0;
  int total    = 0;

  debug_trace_serializer #(.REG_DUMP(0)) dut0 (
    .clk(clk), .resetN(resetN), .enable(en0), .machineCycleDone(mcd),
    .regfileState(regs), .nextPCState(pc), .flagsState(flags),
    .systemCallState(sc), .isrBaseAddressState(isr),
    .interruptEnableState(ie), .exceptionMaskState(mask), .causeState(cause),
    .txData(d0), .txValid(v0), .txReady(rdy0), .busy(b0), .dropCount(dc0)
  );

  debug_trace_serializer #(.REG_DUMP(1)) dut1 (
    .clk(clk), .resetN(resetN), .enable(en1), .machineCycleDone(mcd),
    .regfileState(regs), .nextPCState(pc), .flagsState(flags),
    .systemCallState(sc), .isrBaseAddressState(isr),
    .interruptEnableState(ie), .exceptionMaskState(mask), .causeState(cause),
    .txData(d1), .txValid(v1), .txReady(rdy1), .busy(b1), .dropCount(dc1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    resetN = 1'b0; en0 = 1'b0; en1 = 1'b0; mcd = 1'b0; rdy0 = 1'b0; rdy1 = 1'b0;
    tick; tick;
    resetN = 1'b1;
    tick;
  endtask

  task automatic test_reset;
    regs = '0; pc = '0; isr = '0; flags = '0; sc = '0; mask = '0; cause = '0; ie = 1'b0;
    resetN = 1'b0; en0 = 1'b0; en1 = 1'b0; mcd = 1'b0; rdy0 = 1'b0; rdy1 = 1'b0;
    #3;
    total++;
    if ({v0, b0, d0, dc0} !== 18'd0) $display("FAIL reset_dut0 got v=%b b=%b d=%h dc=%h want all 0", v0, b0, d0, dc0);
    else pass_cnt++;
    total++;
    if ({v1, b1, d1, dc1} !== 18'd0) $display("FAIL reset_dut1 got v=%b b=%b d=%h dc=%h want all 0", v1, b1, d1, dc1);
    else pass_cnt++;
    tick;
    resetN = 1'b1;
    tick;
  endtask

  task automatic test_short_frame;
    logic [7:0] exp_s [16];
    exp_s = '{8'hA5, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h1A, 8'h05,
              8'h03, 8'hFF, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h54};
    do_reset;
    pc = 32'h0000_1000; flags = 4'hA; ie = 1'b1; sc = 8'h05; cause = 5'd3;
    mask = 16'h00FF; isr = 32'h0000_0200;
    rdy0 = 1'b1; en0 = 1'b1; mcd = 1'b1;
    tick;
    mcd = 1'b0;
    for (int k = 0; k < 16; k++) begin
      total++;
      if (v0 !== 1'b1 || d0 !== exp_s[k])
        $display("FAIL short_byte%0d got v=%b d=%h want v=1 d=%h", k, v0, d0, exp_s[k]);
      else pass_cnt++;
      tick;
    end
    total++;
    if (v0 !== 1'b0 || b0 !== 1'b0) $display("FAIL short_idle got v=%b b=%b want 0 0", v0, b0);
    else pass_cnt++;
    en0 = 1'b0;
  endtask

  task automatic test_reg_dump;
    logic [7:0] eb [144];
    logic [7:0] x, prev_d;
    logic       prev_v, prev_r, r;
    int         n;
    do_reset;
    for (int i = 0; i < 32; i++) regs[i] = {4{8'(i)}};
    pc = 32'h89AB_CDEF; flags = 4'h5; ie = 1'b0; sc = 8'h3C; cause = 5'h1F;
    mask = 16'hBEEF; isr = 32'hDEAD_0040;
    eb[0] = 8'hA5; eb[1] = 8'h00;
    eb[2] = 8'hEF; eb[3] = 8'hCD; eb[4] = 8'hAB; eb[5] = 8'h89;
    eb[6] = 8'h05; eb[7] = 8'h3C; eb[8] = 8'h1F; eb[9] = 8'hEF; eb[10] = 8'hBE;
    eb[11] = 8'h40; eb[12] = 8'h00; eb[13] = 8'hAD; eb[14] = 8'hDE;
    for (int i = 0; i < 32; i++)
      for (int b = 0; b < 4; b++) eb[15 + 4*i + b] = 8'(i);
    x = 8'h00;
    for (int i = 0; i < 143; i++) x = x ^ eb[i];
    eb[143] = x;
    en1 = 1'b1; mcd = 1'b1; rdy1 = 1'b0;
    tick;
    mcd = 1'b0; en1 = 1'b0;
    pc = ~pc; flags = ~flags; sc = ~sc; mask = ~mask; isr = ~isr; ie = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = 32'hFFFF_FFFF;
    n = 0; prev_v = 1'b0; prev_r = 1'b0; prev_d = 8'h00;
    for (int cyc = 0; cyc < 3000 && n < 144; cyc++) begin
      r = 1'($urandom_range(0, 1));
      rdy1 = r;
      if (prev_v && !prev_r) begin
        total++;
        if (v1 !== 1'b1 || d1 !== prev_d)
          $display("FAIL dump_stall%0d got v=%b d=%h want v=1 d=%h", n, v1, d1, prev_d);
        else pass_cnt++;
      end
      if (v1 && r) begin
        total++;
        if (d1 !== eb[n]) $display("FAIL dump_byte%0d got %h want %h", n, d1, eb[n]);
        else pass_cnt++;
        n++;
      end
      prev_v = v1; prev_r = r; prev_d = d1;
      tick;
    end
    total++;
    if (n !== 144 || v1 !== 1'b0) $display("FAIL dump_length got %0d bytes v=%b want 144 v=0", n, v1);
    else pass_cnt++;
    rdy1 = 1'b0;
  endtask

  task automatic test_drops;
    do_reset;
    rdy0 = 1'b0; en0 = 1'b1; mcd = 1'b1;
    tick;
    mcd = 1'b0;
    tick;
    repeat (3) begin
      mcd = 1'b1; tick;
      mcd = 1'b0; tick;
    end
    total++;
    if (dc0 !== 8'd3) $display("FAIL drop_three got %h want 03", dc0);
    else pass_cnt++;
    mcd = 1'b1;
    repeat (297) tick;
    mcd = 1'b0;
    total++;
    if (dc0 !== 8'hFF || b0 !== 1'b1) $display("FAIL drop_saturate got dc=%h b=%b want FF 1", dc0, b0);
    else pass_cnt++;
    rdy0 = 1'b1;
    for (int c = 0; c < 40 && b0; c++) tick;
    total++;
    if (b0 !== 1'b0 || dc0 !== 8'hFF) $display("FAIL drop_drain got b=%b dc=%h want 0 FF", b0, dc0);
    else pass_cnt++;
    en0 = 1'b0;
  endtask

  task automatic test_back_to_back;
    int f, b;
    do_reset;
    rdy0 = 1'b1; en0 = 1'b1; mcd = 1'b1;
    tick;
    for (int c = 0; c < 257 * 16; c++) begin
      f = c / 16;
      b = c % 16;
      if (b == 0) begin
        total++;
        if (v0 !== 1'b1 || d0 !== 8'hA5)
          $display("FAIL b2b_header%0d got v=%b d=%h want v=1 d=a5", f, v0, d0);
        else pass_cnt++;
      end else if (b == 1) begin
        total++;
        if (d0 !== 8'(f)) $display("FAIL b2b_seq%0d got %h want %h", f, d0, 8'(f));
        else pass_cnt++;
      end
      tick;
    end
    mcd = 1'b0; en0 = 1'b0;
  endtask

  task automatic test_reset_midframe;
    do_reset;
    rdy0 = 1'b1; en0 = 1'b1; mcd = 1'b1;
    tick;
    mcd = 1'b0;
    repeat (16) tick;
    mcd = 1'b1;
    tick;
    mcd = 1'b0;
    total++;
    if (d0 !== 8'hA5) $display("FAIL midreset_pre_header got %h want a5", d0);
    else pass_cnt++;
    tick;
    total++;
    if (d0 !== 8'h01) $display("FAIL midreset_pre_seq got %h want 01", d0);
    else pass_cnt++;
    repeat (6) tick;
    #2;
    resetN = 1'b0;
    #1;
    total++;
    if (v0 !== 1'b0 || b0 !== 1'b0 || d0 !== 8'h00)
      $display("FAIL midreset_async got v=%b b=%b d=%h want 0 0 00", v0, b0, d0);
    else pass_cnt++;
    tick; tick;
    resetN = 1'b1;
    tick;
    total++;
    if (v0 !== 1'b0) $display("FAIL midreset_no_resume got v=%b want 0", v0);
    else pass_cnt++;
    mcd = 1'b1;
    tick;
    mcd = 1'b0;
    total++;
    if (v0 !== 1'b1 || d0 !== 8'hA5) $display("FAIL midreset_header got v=%b d=%h want 1 a5", v0, d0);
    else pass_cnt++;
    tick;
    total++;
    if (d0 !== 8'h00) $display("FAIL midreset_seq got %h want 00", d0);
    else pass_cnt++;
    repeat (16) tick;
    en0 = 1'b0;
  endtask

  task automatic test_enable_low;
    do_reset;
    en0 = 1'b0; rdy0 = 1'b1;
    repeat (5) begin
      mcd = 1'b1; tick;
      mcd = 1'b0; tick;
    end
    total++;
    if (v0 !== 1'b0 || b0 !== 1'b0 || dc0 !== 8'd0)
      $display("FAIL en_low_idle got v=%b b=%b dc=%h want 0 0 00", v0, b0, dc0);
    else pass_cnt++;
    en0 = 1'b1; mcd = 1'b1;
    tick;
    en0 = 1'b0;
    total++;
    if (v0 !== 1'b1 || d0 !== 8'hA5) $display("FAIL en_low_start got v=%b d=%h want 1 a5", v0, d0);
    else pass_cnt++;
    repeat (20) tick;
    mcd = 1'b0;
    total++;
    if (v0 !== 1'b0 || b0 !== 1'b0 || dc0 !== 8'd0)
      $display("FAIL en_low_complete got v=%b b=%b dc=%h want 0 0 00", v0, b0, dc0);
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_short_frame;
    test_reg_dump;
    test_drops;
    test_back_to_back;
    test_reset_midframe;
    test_enable_low;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
